// File: rtl/out_rr_arbiter.sv
// Round-robin arbiter sharing one registered output word among N valid/ready
// requesters; each grant lasts up to BURST beats or until the grantee drops valid.
module out_rr_arbiter #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int BURST = 4
) (
    input  logic                   ref_clk,
    input  logic                   rst,
    input  logic [N-1:0]           req_valid,
    input  logic [N*WIDTH-1:0]     req_data,
    output logic [N-1:0]           req_ready,
    output logic [WIDTH-1:0]       out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(N)-1:0]   grant_id,
    output logic                   busy
);

    localparam int GW = $clog2(N);
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q, state_d;
    logic [GW-1:0]      last_q, last_d;
    logic [GW-1:0]      g_q, g_d;
    logic [GW-1:0]      grant_id_q, grant_id_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               out_valid_q, out_valid_d;

    logic               found;
    logic [GW-1:0]      pick;
    logic               xfer;
    logic [WIDTH-1:0]   sel_data;

    // The output register can take a word when empty or being drained this cycle.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_ready
            assign req_ready[gi] = (state_q == GRANT) && (g_q == GW'(gi)) &&
                                   (!out_valid_q || out_ready);
        end
    endgenerate

    // Search starts just after the last grantee so it has lowest priority.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= N; k++) begin
            if (!found && req_valid[(int'(last_q) + k) % N]) begin
                found = 1'b1;
                pick  = GW'((int'(last_q) + k) % N);
            end
        end
    end

    assign xfer     = req_valid[g_q] && req_ready[g_q];
    assign sel_data = req_data[g_q*WIDTH +: WIDTH];

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        g_d         = g_q;
        grant_id_d  = grant_id_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = out_ready ? 1'b0 : out_valid_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    g_d        = pick;
                    grant_id_d = pick;
                    cnt_d      = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (!req_valid[g_q]) begin
                    state_d = IDLE;
                    last_d  = g_q;
                end else if (xfer) begin
                    out_d       = sel_data;
                    out_valid_d = 1'b1;
                    cnt_d       = cnt_q + 1'b1;
                    if (cnt_q == CW'(BURST - 1)) begin
                        state_d = IDLE;
                        last_d  = g_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ref_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= GW'(N - 1);
            g_q         <= '0;
            grant_id_q  <= '0;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            g_q         <= g_d;
            grant_id_q  <= grant_id_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign grant_id  = grant_id_q;
    assign busy      = (state_q == GRANT);

endmodule
